// File: rtl/safe_zone_map.sv
// Procedural safe-cell map generator for a block-grid playfield, plus NUM_PORTS registered
// pixel-coordinate lookup ports. Cells are filled one per cycle, and each cell's odds depend on
// its upper, left and upper-left neighbours.
module safe_zone_map #(
  parameter int unsigned             SCREEN_WIDTH  = 400,
  parameter int unsigned             SCREEN_HEIGHT = 600,
  parameter int unsigned             BLOCK_SIZE    = 20,
  parameter int unsigned             RAND_WIDTH    = 8,
  parameter logic [RAND_WIDTH-1:0]   TAPS          = 8'hB8,
  parameter logic [RAND_WIDTH:0]     P_ALL3        = 9'd25,
  parameter logic [RAND_WIDTH:0]     P_UL          = 9'd128,
  parameter logic [RAND_WIDTH:0]     P_NONE        = 9'd64,
  parameter logic [RAND_WIDTH:0]     P_OTHER       = 9'd76,
  parameter int unsigned             SPAWN_COL     = 0,
  parameter int unsigned             SPAWN_ROW     = SCREEN_HEIGHT / BLOCK_SIZE - 1,
  parameter int unsigned             NUM_PORTS     = 2,
  localparam int unsigned            COLS          = SCREEN_WIDTH / BLOCK_SIZE,
  localparam int unsigned            ROWS          = SCREEN_HEIGHT / BLOCK_SIZE,
  localparam int unsigned            N             = COLS * ROWS,
  localparam int unsigned            XW            = $clog2(SCREEN_WIDTH),
  localparam int unsigned            YW            = $clog2(SCREEN_HEIGHT),
  localparam int unsigned            CntW          = $clog2(N + 1)
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           i_regenerate_level,
  input  logic [RAND_WIDTH-1:0]          i_seed,
  output logic                           o_rdy,
  output logic                           o_done,
  output logic [CntW-1:0]                o_safe_count,
  input  logic [NUM_PORTS-1:0][XW-1:0]   i_x,
  input  logic [NUM_PORTS-1:0][YW-1:0]   i_y,
  output logic [NUM_PORTS-1:0]           o_is_safe
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [IW-1:0]   ColsI    = IW'(COLS);
  localparam logic [IW-1:0]   OneI     = IW'(1);
  localparam logic [IW-1:0]   LastIdx  = IW'(N - 1);
  localparam logic [IW-1:0]   SpawnIdx = IW'(SPAWN_ROW * COLS + SPAWN_COL);
  localparam logic [CW-1:0]   LastCol  = CW'(COLS - 1);
  localparam logic [CW-1:0]   OneC     = CW'(1);
  localparam logic [RW-1:0]   OneR     = RW'(1);
  localparam logic [CntW-1:0] OneCnt   = CntW'(1);
  localparam logic [XW:0]     XLim     = (XW + 1)'(SCREEN_WIDTH);
  localparam logic [YW:0]     YLim     = (YW + 1)'(SCREEN_HEIGHT);

  typedef enum logic [1:0] {StEmpty, StGen, StReady} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [RAND_WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic [NUM_PORTS-1:0]   is_safe_q, is_safe_d;
  logic [N-1:0]           map_q;

  logic                   map_we;
  logic                   up, left, diag;
  logic [RAND_WIDTH:0]    thr;
  logic                   cell_safe;

  // Neighbours come from cells already written earlier in this same pass.
  always_comb begin
    up   = 1'b0;
    left = 1'b0;
    diag = 1'b0;
    if (row_q != '0) up = map_q[idx_q - ColsI];
    if (col_q != '0) left = map_q[idx_q - OneI];
    if ((row_q != '0) && (col_q != '0)) diag = map_q[idx_q - ColsI - OneI];

    if (up && left && diag)     thr = P_ALL3;
    else if (up && left)        thr = P_UL;
    else if (!(up || left || diag)) thr = P_NONE;
    else                        thr = P_OTHER;

    cell_safe = ({1'b0, lfsr_q} < thr) || (idx_q == SpawnIdx);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    col_d   = col_q;
    row_d   = row_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    map_we  = 1'b0;

    if (i_regenerate_level) begin
      state_d = StGen;
      idx_d   = '0;
      col_d   = '0;
      row_d   = '0;
      cnt_d   = '0;
      lfsr_d  = (i_seed == '0) ? '1 : i_seed;
    end else if (state_q == StGen) begin
      map_we = 1'b1;
      if (cell_safe) cnt_d = cnt_q + OneCnt;
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
      if (idx_q == LastIdx) begin
        state_d = StReady;
        done_d  = 1'b1;
      end else begin
        idx_d = idx_q + OneI;
        if (col_q == LastCol) begin
          col_d = '0;
          row_d = row_q + OneR;
        end else begin
          col_d = col_q + OneC;
        end
      end
    end
  end

  // Out-of-range coordinates are masked before the (possibly out-of-range) map read matters.
  logic [NUM_PORTS-1:0][IW-1:0] q_idx;
  logic [NUM_PORTS-1:0]         q_ok;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      q_idx[p] = IW'(i_y[p] / YW'(BLOCK_SIZE)) * ColsI + IW'(i_x[p] / XW'(BLOCK_SIZE));
      q_ok[p]  = ({1'b0, i_x[p]} < XLim) && ({1'b0, i_y[p]} < YLim);
      is_safe_d[p] = (state_q == StReady) && q_ok[p] && map_q[q_idx[p]];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= StEmpty;
      idx_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      lfsr_q    <= '1;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      is_safe_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      col_q     <= col_d;
      row_q     <= row_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      is_safe_q <= is_safe_d;
    end
  end

  // Map contents are only visible in READY, so they need no reset.
  always_ff @(posedge clk) begin
    if (map_we) map_q[idx_q] <= cell_safe;
  end

  assign o_rdy        = (state_q == StReady);
  assign o_done       = done_q;
  assign o_safe_count = cnt_q;
  assign o_is_safe    = is_safe_q;

endmodule

// File: doc/safe_zone_map.md
SAFE_ZONE_MAP -- requirements
Module: safe_zone_map

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 400, pixel width of the playfield.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 600, pixel height of the playfield.
REQ-003 SHALL have parameter BLOCK_SIZE, default 20, cell edge in pixels; COLS=SCREEN_WIDTH/BLOCK_SIZE, ROWS=SCREEN_HEIGHT/BLOCK_SIZE, N=COLS*ROWS.
REQ-004 SHALL have parameter RAND_WIDTH, default 8, LFSR width.
REQ-005 SHALL have parameter TAPS, default 8'hB8, Galois LFSR feedback mask, RAND_WIDTH bits.
REQ-006 SHALL have parameters P_ALL3/P_UL/P_NONE/P_OTHER, defaults 25/128/64/76, thresholds of RAND_WIDTH+1 bits; 2**RAND_WIDTH means always safe.
REQ-007 SHALL have parameters SPAWN_COL, default 0, and SPAWN_ROW, default ROWS-1, the forced-safe cell.
REQ-008 SHALL have parameter NUM_PORTS, default 2, number of independent query ports.
REQ-009 clk  in  1  sole clock, rising edge.
REQ-010 arst_n  in  1  reset, asynchronous, active-low.
REQ-011 i_regenerate_level  in  1  start/restart map generation; sampled on clk.
REQ-012 i_seed  in  RAND_WIDTH  LFSR seed, sampled with i_regenerate_level.
REQ-013 o_rdy  out  1  map valid, queries answered.
REQ-014 o_done  out  1  one-cycle pulse on generation completion.
REQ-015 o_safe_count  out  clog2(N+1)  number of safe cells in the map.
REQ-016 i_x  in  NUM_PORTS x clog2(SCREEN_WIDTH)  per-port query x, pixels.
REQ-017 i_y  in  NUM_PORTS x clog2(SCREEN_HEIGHT)  per-port query y, pixels.
REQ-018 o_is_safe  out  NUM_PORTS  per-port query result.

Function
REQ-019 FSM states EMPTY, GEN, READY SHALL exist; EMPTY after reset; o_rdy=1 only in READY.
REQ-020 i_regenerate_level=1 at any edge, in any state, SHALL enter GEN with col=row=0, safe_count=0, LFSR=i_seed (seed 0 loads all-ones).
REQ-021 In GEN one cell per cycle, row-major (col fastest); cell (col,row) written at the (row*COLS+col+1)-th edge after the sampling edge.
REQ-022 Neighbours: up=row>0&&map[row-1][col]; left=col>0&&map[row][col-1]; diag=row>0&&col>0&&map[row-1][col-1]; values from the map being generated.
REQ-023 Threshold: up&&left&&diag->P_ALL3; else up&&left->P_UL; else none set->P_NONE; else P_OTHER.
REQ-024 Cell safe = (LFSR state < threshold), compared at RAND_WIDTH+1 bits; cell (SPAWN_COL,SPAWN_ROW) SHALL be forced safe.
REQ-025 LFSR SHALL advance once per GEN cycle after use: lsb=1 -> (s>>1)^TAPS, else s>>1; frozen outside GEN.
REQ-026 o_safe_count SHALL increment for each safe cell written; holds in READY.
REQ-027 After last cell write (edge N) state SHALL be READY, o_rdy=1 and o_done=1 for that one cycle.
REQ-028 Regenerate asserted during GEN SHALL restart with no o_done for the aborted pass.
REQ-029 Query: o_is_safe[p] registered, 1-cycle latency, = map[i_y/BLOCK_SIZE][i_x/BLOCK_SIZE] sampled at the edge.
REQ-030 o_is_safe[p]=0 when not READY at the sampling edge, or i_x>=SCREEN_WIDTH, or i_y>=SCREEN_HEIGHT.
REQ-031 Same seed and parameters SHALL reproduce a bit-identical map.

Reset
REQ-032 arst_n=0 SHALL immediately force state EMPTY, o_rdy=0, o_done=0, o_safe_count=0, o_is_safe=0, LFSR=all-ones, counters 0, including mid-GEN.
REQ-033 Map storage need not be cleared; it SHALL be unobservable until next READY.
REQ-034 Deassertion needs no synchronisation beyond arst_n released away from a clk edge by the bench.

Verification
REQ-035 Reset mid-GEN (cell 300) -> all outputs 0 asynchronously; EMPTY; queries 0 until regenerate.
REQ-036 Defaults, seed 8'h01 -> o_rdy rises exactly 600 edges after sampling edge; single o_done; map and o_safe_count match bit-level model; cell (0,29) safe.
REQ-037 Seed 8'h00 vs 8'hFF -> identical maps and counts.
REQ-038 READY, port0 (0,0), port1 (399,599), then port0 (400,0) and (0,600) -> first two match model one cycle later; last two return 0.
REQ-039 Second regenerate at cell 300 -> no o_done at edge 600 of first pass; o_rdy 600 edges after second pulse.
REQ-040 All P_*=0 -> o_safe_count=1 (spawn only); all P_*=256 -> o_safe_count=600.
